crossbar_arb: RTL and testbench

Parametrised N-input by M-output registered crossbar switch with per-output round-robin arbitration and valid/ready flow control on every port. Each input word carries its own destination index, so several inputs may target the same output in one cycle. Successor to the fixed 2x2 combinational crossbar. Sits between producer lanes and consumer lanes wherever contention and backpressure must be handled in hardware.

---
 rtl/crossbar_arb_pkg.sv | 37 +++
 rtl/crossbar_arb_rr_arbiter.sv | 61 ++++++
 rtl/crossbar_arb.sv | 133 +++++++++++++
 tb/tb_crossbar_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_arb_pkg
// Purpose  : Shared constants and elaboration-time helpers for the crossbar
//            switch: ceil(log2) function, index-width derivation (at least
//            one bit) and the legal parameter range check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package crossbar_arb_pkg;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 16;

  // ceil(log2(value)); 0 for value <= 1
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) result = k + 1;
    end
    return result;
  endfunction

  // Width of an index that selects one of n items, never narrower than 1 bit
  function automatic int dest_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit params_ok(input int n_in, input int n_out, input int width);
    return (n_in  >= MIN_PORTS) && (n_in  <= MAX_PORTS) &&
           (n_out >= MIN_PORTS) && (n_out <= MAX_PORTS) &&
           (width >= 1);
  endfunction

endpackage : crossbar_arb_pkg
`default_nettype wire

// File: rtl/crossbar_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter over N requesters. The pointer remembers the
//            last granted requester; the search starts one past it and wraps.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            req[N]         - request vector
//            advance        - consumer can take a grant this cycle; the
//                             pointer moves to the winner when a request exists
//            grant[N]       - one-hot grant (combinational)
//            grant_idx      - binary index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import crossbar_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = dest_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;

  // Walk the candidates from farthest to nearest so the nearest requester
  // after the pointer is the last (and therefore winning) assignment.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = int'(r_ptr) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        grant           = '0;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  // Reset to N-1 so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (advance && (|req)) begin
      r_ptr <= grant_idx;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/crossbar_arb.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_arb
// Purpose  : N_IN x N_OUT registered crossbar with per-output round-robin
//            arbitration and valid/ready flow control on every port.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            in_data[N_IN*WIDTH] - input words, port i at [i*WIDTH +: WIDTH]
//            in_dest[N_IN*DEST_W]- destination output index per input
//            in_valid[N_IN]      - input word present
//            in_ready[N_IN]      - input word accepted (combinational)
//            out_data[N_OUT*WIDTH]- registered output words
//            out_valid[N_OUT]    - registered output word present
//            out_ready[N_OUT]    - consumer accepts output word
//            err_dest            - sticky: an out-of-range destination was seen
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_arb
  import crossbar_arb_pkg::*;
#(
  parameter  int N_IN   = 4,
  parameter  int N_OUT  = 4,
  parameter  int WIDTH  = 4,
  localparam int DEST_W = dest_width(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN*DEST_W-1:0]  in_dest,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*WIDTH-1:0]  out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_dest
);

  localparam int IDX_W = dest_width(N_IN);
  // One extra bit so the range compare stays meaningful when N_OUT == 2**DEST_W
  localparam logic [DEST_W:0] N_OUT_EXT = (DEST_W + 1)'(N_OUT);

  if (!params_ok(N_IN, N_OUT, WIDTH)) begin : g_param_check
    $error("crossbar_arb: N_IN/N_OUT must be 2..16 and WIDTH >= 1");
  end

  logic [DEST_W-1:0] w_dest      [N_IN];
  logic [WIDTH-1:0]  w_in_word   [N_IN];
  logic [N_IN-1:0]   w_req       [N_OUT];
  logic [N_IN-1:0]   w_grant     [N_OUT];
  logic [IDX_W-1:0]  w_grant_idx [N_OUT];
  logic [N_IN-1:0]   w_bad;
  logic [N_OUT-1:0]  w_free;
  logic [N_OUT-1:0]  w_load;

  logic [WIDTH-1:0]  r_out_data [N_OUT];
  logic [N_OUT-1:0]  r_out_valid;
  logic              r_err_dest;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign w_dest[i]    = in_dest[i*DEST_W +: DEST_W];
    assign w_in_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Request decode: each valid input raises exactly one request (or is bad).
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_req[o] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_req[o][i] = in_valid[i] && (w_dest[i] == DEST_W'(o));
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      w_bad[i] = in_valid[i] && ({1'b0, w_dest[i]} >= N_OUT_EXT);
    end
  end

  // An output can take a new word when empty or when its word leaves now.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_free[o] = !r_out_valid[o] || out_ready[o];
      w_load[o] = w_free[o] && (|w_req[o]);
    end
  end

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    rr_arbiter #(
      .N (N_IN)
    ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (w_req[o]),
      .advance   (w_free[o]),
      .grant     (w_grant[o]),
      .grant_idx (w_grant_idx[o])
    );
  end

  // Bad destinations are consumed (dropped) so they never block the lane.
  always_comb begin
    in_ready = w_bad;
    for (int o = 0; o < N_OUT; o++) begin
      in_ready = in_ready | (w_grant[o] & {N_IN{w_free[o]}});
    end
    if (!rst_n) in_ready = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_OUT; o++) r_out_data[o] <= '0;
      r_out_valid <= '0;
      r_err_dest  <= 1'b0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        if (w_free[o]) begin
          r_out_valid[o] <= w_load[o];
          if (w_load[o]) r_out_data[o] <= w_in_word[w_grant_idx[o]];
        end
      end
      r_err_dest <= r_err_dest | (|w_bad);
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < N_OUT; o++) begin
      out_data[o*WIDTH +: WIDTH] = r_out_data[o];
    end
  end

  assign out_valid = r_out_valid;
  assign err_dest  = r_err_dest;

endmodule : crossbar_arb
`default_nettype wire

// File: tb/tb_crossbar_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_crossbar_arb
// Purpose  : Self-checking bench for crossbar_arb: a 4x4 instance for reset,
//            routing, contention, backpressure and a scoreboarded random run,
//            and a 4x3 instance for the out-of-range destination case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crossbar_arb;

  logic        clk = 1'b0;
  logic        rst_n;

  // 4x4 instance
  logic [15:0] in_data;
  logic [7:0]  in_dest;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_dest;

  // 4x3 instance
  logic [15:0] in_data3;
  logic [7:0]  in_dest3;
  logic [3:0]  in_valid3;
  logic [3:0]  in_ready3;
  logic [11:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        err_dest3;

  int checks = 0;
  int errors = 0;

  crossbar_arb #(.N_IN(4), .N_OUT(4), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_dest(err_dest)
  );

  crossbar_arb #(.N_IN(4), .N_OUT(3), .WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_dest(in_dest3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_dest(err_dest3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input bit v, input int d, input logic [3:0] data);
    in_valid[i]        = v;
    in_dest[i*2 +: 2]  = 2'(d);
    in_data[i*4 +: 4]  = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard: one queue per (input, output) pair, index src*4 + dst.
  // Word format in the random run: {src[1:0], seq[1:0]}.
  logic [3:0] sb_q [16][$];
  logic [1:0] seq  [16];
  bit         pend_v    [4];
  int         pend_d    [4];
  logic [3:0] pend_data [4];

  task automatic sample_deliveries();
    int         k;
    logic [3:0] w;
    logic [3:0] e;
    for (int o = 0; o < 4; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        w = out_data[o*4 +: 4];
        k = int'(w[3:2]) * 4 + o;
        check("sb_word_expected", 32'(sb_q[k].size() != 0), 32'd1);
        if (sb_q[k].size() != 0) begin
          e = sb_q[k].pop_front();
          check("sb_order", 32'(w), 32'(e));
        end
      end
    end
  endtask

  initial begin
    int exp_src;
    int remaining;

    rst_n      = 1'b0;
    in_data    = '0;
    in_dest    = '0;
    in_valid   = 4'hF;   // valid inputs during reset must still see in_ready = 0
    out_ready  = 4'hF;
    in_data3   = '0;
    in_dest3   = '0;
    in_valid3  = '0;
    out_ready3 = 3'b111;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_err_dest",  32'(err_dest),  32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_err_dest3", 32'(err_dest3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- parallel routing (input i -> output 3-i) ----------------
    in_valid = 4'hF;
    in_data  = 16'hABCD;
    in_dest  = {2'd0, 2'd1, 2'd2, 2'd3};
    out_ready = 4'hF;
    #1;
    check("perm_in_ready", 32'(in_ready), 32'hF);
    @(posedge clk); #1;
    check("perm_out_valid", 32'(out_valid), 32'hF);
    check("perm_out_data",  32'(out_data),  32'hDCBA);

    // ---------------- asynchronous reset mid-traffic ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_out_data",  32'(out_data),  32'h0);
    check("async_rst_in_ready",  32'(in_ready),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- contention: inputs 0,1,2 -> output 1 ----------------
    in_valid = '0;
    drive(0, 1'b1, 1, 4'h1);
    drive(1, 1'b1, 1, 4'h2);
    drive(2, 1'b1, 1, 4'h3);
    drive(3, 1'b0, 0, 4'h0);
    out_ready = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_src = k % 3;
      #1;
      check("cont_in_ready", 32'(in_ready), 32'(1 << exp_src));
      @(posedge clk); #1;
      check("cont_out_data",  32'(out_data[7:4]), 32'(exp_src + 1));
      check("cont_out_valid", 32'(out_valid[1]), 32'h1);
      @(negedge clk);
    end

    // ---------------- backpressure on output 2 ----------------
    in_valid = '0;
    do_reset();
    drive(0, 1'b1, 2, 4'h9);
    out_ready = 4'hF;
    @(posedge clk); #1;
    check("bp_load_data",  32'(out_data[11:8]), 32'h9);
    check("bp_load_valid", 32'(out_valid[2]),   32'h1);
    @(negedge clk);
    drive(0, 1'b0, 0, 4'h0);
    drive(1, 1'b1, 2, 4'h5);
    out_ready = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready_low", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      check("bp_hold_data",  32'(out_data[11:8]), 32'h9);
      check("bp_hold_valid", 32'(out_valid[2]),   32'h1);
      @(negedge clk);
    end
    out_ready = 4'hF;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    check("bp_release_data",  32'(out_data[11:8]), 32'h5);
    check("bp_release_valid", 32'(out_valid[2]),   32'h1);
    check("bp_err_dest",      32'(err_dest),       32'h0);
    @(negedge clk);
    in_valid = '0;

    // ---------------- bad destination on the 4x3 instance ----------------
    in_valid3 = 4'b0010;
    in_dest3  = {2'd0, 2'd0, 2'd3, 2'd0};
    in_data3  = 16'h0070;
    #1;
    check("bad_in_ready", 32'(in_ready3), 32'h2);
    @(posedge clk); #1;
    check("bad_no_load", 32'(out_valid3), 32'h0);
    check("bad_err_set", 32'(err_dest3),  32'h1);
    @(negedge clk);
    in_valid3 = 4'b0001;
    in_dest3  = {2'd0, 2'd0, 2'd0, 2'd2};
    in_data3  = 16'h0006;
    #1;
    check("bad_legal_ready", 32'(in_ready3), 32'h1);
    @(posedge clk); #1;
    check("bad_legal_data",  32'(out_data3[11:8]), 32'h6);
    check("bad_legal_valid", 32'(out_valid3),      32'h4);
    @(negedge clk);
    in_valid3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("bad_err_sticky", 32'(err_dest3), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("bad_err_cleared", 32'(err_dest3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- random stress with scoreboard ----------------
    for (int k = 0; k < 16; k++) seq[k] = '0;
    for (int i = 0; i < 4; i++) begin
      pend_v[i] = 1'b0; pend_d[i] = 0; pend_data[i] = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 3) != 0)) begin
          pend_v[i]    = 1'b1;
          pend_d[i]    = int'($urandom_range(0, 3));
          pend_data[i] = {2'(i), seq[i*4 + pend_d[i]]};
          seq[i*4 + pend_d[i]] = seq[i*4 + pend_d[i]] + 2'd1;
        end
        drive(i, pend_v[i], pend_d[i], pend_data[i]);
      end
      out_ready = 4'($urandom_range(0, 15));
      #1;
      check("rand_ready_needs_valid", 32'(in_ready & ~in_valid), 32'h0);
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          sb_q[i*4 + pend_d[i]].push_back(pend_data[i]);
          pend_v[i] = 1'b0;
        end
      end
      sample_deliveries();
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = '0;
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      sample_deliveries();
      @(posedge clk);
      @(negedge clk);
    end
    remaining = 0;
    for (int k = 0; k < 16; k++) remaining += sb_q[k].size();
    check("rand_all_delivered", 32'(remaining), 32'h0);
    check("rand_err_dest",      32'(err_dest),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_crossbar_arb
`default_nettype wire
